cov_harness_seq: RTL

Parametrised reset sequencer and coverage monitor for formal/fuzz harness tops around a generated DUT. It generates a two-phase DUT reset: metaReset phase, then ordinary reset phase, each of configurable length. It gates coverage sampling and assertion checking to the post-reset window. Per bit of a DUT cover vector, it accumulates sticky seen-high/seen-low flags, and it latches the first assertion failure together with its cycle stamp.

---
 rtl/cov_harness_if.sv | 30 +++
 rtl/cov_harness_seq.sv | 79 +++++++
 2 files changed

// File: rtl/cov_harness_if.sv
// cov_harness_if: coverage/assertion bus between a harness top and the reset sequencer
interface cov_harness_if #(
    parameter int COV_WIDTH = 19,
    parameter int CNT_WIDTH = 16
);
    logic [COV_WIDTH-1:0] cov_in;
    logic                 assert_in;
    logic                 clear;
    logic                 dut_meta_reset;
    logic                 dut_reset;
    logic                 active;
    logic [COV_WIDTH-1:0] seen_high;
    logic [COV_WIDTH-1:0] seen_low;
    logic                 all_covered;
    logic                 assert_fail;
    logic [CNT_WIDTH-1:0] assert_cycle;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output cov_in, assert_in, clear,
        input  dut_meta_reset, dut_reset, active, seen_high, seen_low,
               all_covered, assert_fail, assert_cycle, cycle_count
    );

    modport slave (
        input  cov_in, assert_in, clear,
        output dut_meta_reset, dut_reset, active, seen_high, seen_low,
               all_covered, assert_fail, assert_cycle, cycle_count
    );
endinterface

// File: rtl/cov_harness_seq.sv
// cov_harness_seq: two-phase DUT reset sequencer with post-reset coverage and first-failure capture
module cov_harness_seq #(
    parameter int COV_WIDTH    = 19,
    parameter int META_CYCLES  = 1,
    parameter int RESET_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input logic          clock,
    input logic          reset,
    cov_harness_if.slave bus
);
    localparam int MAXP = META_CYCLES > RESET_CYCLES ? META_CYCLES : RESET_CYCLES;
    localparam int PW   = $clog2(MAXP + 1);

    typedef enum logic [1:0] {META, RST, RUN, HALT} state_t;

    state_t               state = META;
    state_t               state_n;
    logic [PW-1:0]        phase = '0;
    logic                 phase_done;
    logic [COV_WIDTH-1:0] seen_high = '0;
    logic [COV_WIDTH-1:0] seen_low = '0;
    logic [CNT_WIDTH-1:0] cycle_count = '0;
    logic [CNT_WIDTH-1:0] assert_cycle = '0;
    logic                 assert_fail = 1'b0;

    always_comb begin
        phase_done = state == META ? phase == PW'(META_CYCLES - 1)
                                   : phase == PW'(RESET_CYCLES - 1);
        state_n = state;
        if (reset)
            state_n = META;
        else if (state == META && phase_done)
            state_n = RESET_CYCLES == 0 ? RUN : RST;
        else if (state == RST && phase_done)
            state_n = RUN;
        else if (state == RUN && bus.assert_in)
            state_n = HALT;
    end

    always_ff @(posedge clock) begin
        state <= state_n;
        phase <= (reset || state_n != state || state == RUN || state == HALT) ? '0 : phase + PW'(1);
    end

    // a failing cycle's sample is dropped: the trace is no longer valid
    always_ff @(posedge clock) begin
        if (reset) begin
            seen_high    <= '0;
            seen_low     <= '0;
            cycle_count  <= '0;
            assert_cycle <= '0;
            assert_fail  <= 1'b0;
        end else if (state == RUN) begin
            if (bus.assert_in) begin
                assert_fail  <= 1'b1;
                assert_cycle <= cycle_count;
            end else if (bus.clear) begin
                seen_high   <= '0;
                seen_low    <= '0;
                cycle_count <= '0;
            end else begin
                seen_high   <= seen_high | bus.cov_in;
                seen_low    <= seen_low | ~bus.cov_in;
                cycle_count <= &cycle_count ? cycle_count : cycle_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.dut_meta_reset = state == META;
    assign bus.dut_reset      = state == META || state == RST;
    assign bus.active         = state == RUN;
    assign bus.seen_high      = seen_high;
    assign bus.seen_low       = seen_low;
    assign bus.all_covered    = &(seen_high & seen_low);
    assign bus.assert_fail    = assert_fail;
    assign bus.assert_cycle   = assert_cycle;
    assign bus.cycle_count    = cycle_count;
endmodule
